// File: rtl/datapath_pkg.sv
// Shared datapath constants and types for the operand / shifter stage.
package datapath_pkg;

    localparam int DW   = 16;
    localparam int NREG = 8;
    localparam int RW   = 3;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  regidx_t;
    typedef logic [1:0]  shcode_t;

    // Shift codes understood by the downstream shifter.
    localparam shcode_t SH_PASS = 2'b00;
    localparam shcode_t SH_LSL  = 2'b01;
    localparam shcode_t SH_LSR  = 2'b10;
    localparam shcode_t SH_ASR  = 2'b11;

endpackage : datapath_pkg

// File: rtl/regfile8x16.sv
// Register file: NREG words, one synchronous write port, one combinational
// read port. Indices at or above NREG drop writes and read as zero.
module regfile8x16
    import datapath_pkg::*;
#(
    parameter int DW   = datapath_pkg::DW,
    parameter int NREG = datapath_pkg::NREG,
    parameter int RW   = datapath_pkg::RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [NREG];
    logic [DW-1:0] mem_d [NREG];

    // Next contents: only the addressed in-range word takes the write data.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            if (we && (int'(waddr) == i)) begin
                mem_d[i] = wdata;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Combinational read port; out-of-range indices return zero.
    always_comb begin
        rdata = {DW{1'b0}};
        if (int'(raddr) < NREG) begin
            rdata = mem_q[raddr];
        end else begin
            rdata = {DW{1'b0}};
        end
    end

    // Storage update with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule : regfile8x16

// File: rtl/operand_regfile_stage.sv
// Operand stage ahead of the 16-bit shifter: register file, operand A/B
// latches with a valid/ready pair handshake and a sticky overrun flag.
// Optional macro REGFILE_BYPASS_EN forwards data_in to a load that reads
// the register being written in the same cycle.
module operand_regfile_stage
    import datapath_pkg::*;
#(
    parameter int DW   = datapath_pkg::DW,
    parameter int NREG = datapath_pkg::NREG,
    parameter int RW   = datapath_pkg::RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          write,
    input  logic [RW-1:0] writenum,
    input  logic [DW-1:0] data_in,
    input  logic [RW-1:0] readnum,
    input  logic          loada,
    input  logic          loadb,
    input  logic [1:0]    shift_in,
    output logic          a_ready,
    output logic          b_ready,
    output logic [DW-1:0] aout,
    output logic [DW-1:0] bout,
    output logic [1:0]    shift_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overrun_err
);

    logic [DW-1:0] rf_rdata;
    logic [DW-1:0] rd_word;
    logic          consume;
    logic          a_load;
    logic          b_load;

    logic          a_full_q, a_full_d;
    logic          b_full_q, b_full_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic [DW-1:0] aout_q, aout_d;
    logic [DW-1:0] bout_q, bout_d;
    logic [1:0]    shcode_q, shcode_d;

    regfile8x16 #(
        .DW   (DW),
        .NREG (NREG),
        .RW   (RW)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (write),
        .waddr (writenum),
        .wdata (data_in),
        .raddr (readnum),
        .rdata (rf_rdata)
    );

    // Operand source: register read, optionally forwarded from a same-cycle write.
    always_comb begin
        rd_word = rf_rdata;
`ifdef REGFILE_BYPASS_EN
        if (write && (writenum == readnum)) begin
            rd_word = data_in;
        end else begin
            rd_word = rf_rdata;
        end
`endif
    end

    // Handshake: a held pair is consumed when downstream is ready; a latch
    // freed by that consume can reload in the same cycle.
    always_comb begin
        consume = valid_q & out_ready;
        a_ready = ~a_full_q | consume;
        b_ready = ~b_full_q | consume;
        a_load  = loada & a_ready;
        b_load  = loadb & b_ready;
    end

    // Next-state for latches, occupancy flags and the sticky overrun flag.
    always_comb begin
        aout_d    = aout_q;
        bout_d    = bout_q;
        shcode_d  = shcode_q;
        a_full_d  = a_full_q;
        b_full_d  = b_full_q;
        overrun_d = overrun_q | (loada & ~a_ready) | (loadb & ~b_ready);

        if (a_load) begin
            aout_d   = rd_word;
            a_full_d = 1'b1;
        end else if (consume) begin
            a_full_d = 1'b0;
        end else begin
            a_full_d = a_full_q;
        end

        if (b_load) begin
            bout_d   = rd_word;
            shcode_d = shift_in;
            b_full_d = 1'b1;
        end else if (consume) begin
            b_full_d = 1'b0;
        end else begin
            b_full_d = b_full_q;
        end

        valid_d = a_full_d & b_full_d;
    end

    // State registers with synchronous active-low reset discarding any pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aout_q    <= {DW{1'b0}};
            bout_q    <= {DW{1'b0}};
            shcode_q  <= SH_PASS;
            a_full_q  <= 1'b0;
            b_full_q  <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            aout_q    <= aout_d;
            bout_q    <= bout_d;
            shcode_q  <= shcode_d;
            a_full_q  <= a_full_d;
            b_full_q  <= b_full_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign aout        = aout_q;
    assign bout        = bout_q;
    assign shift_q     = shcode_q;
    assign out_valid   = valid_q;
    assign overrun_err = overrun_q;

endmodule : operand_regfile_stage

// File: tb/tb_operand_regfile_stage.sv
// Directed table-driven bench for operand_regfile_stage.
module tb_operand_regfile_stage;

    logic        clk;
    logic        rst_n;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic [2:0]  readnum;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift_in;
    logic        a_ready;
    logic        b_ready;
    logic [15:0] aout;
    logic [15:0] bout;
    logic [1:0]  shift_q;
    logic        out_valid;
    logic        out_ready;
    logic        overrun_err;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef REGFILE_BYPASS_EN
    localparam logic [15:0] COLL_EXP = 16'h00FF;
`else
    localparam logic [15:0] COLL_EXP = 16'h0001;
`endif

    typedef struct {
        logic        rst_n;
        logic        wr;
        logic [2:0]  wn;
        logic [15:0] din;
        logic [2:0]  rn;
        logic        la;
        logic        lb;
        logic [1:0]  sh;
        logic        ordy;
        logic [15:0] e_aout;
        logic [15:0] e_bout;
        logic [1:0]  e_sh;
        logic        e_valid;
        logic        e_ovr;
    } vec_t;

    vec_t vecs[$];

    operand_regfile_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write       (write),
        .writenum    (writenum),
        .data_in     (data_in),
        .readnum     (readnum),
        .loada       (loada),
        .loadb       (loadb),
        .shift_in    (shift_in),
        .a_ready     (a_ready),
        .b_ready     (b_ready),
        .aout        (aout),
        .bout        (bout),
        .shift_q     (shift_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun_err (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst_n     = 1'b1;
        write     = 1'b0;
        writenum  = 3'd0;
        data_in   = 16'h0000;
        readnum   = 3'd0;
        loada     = 1'b0;
        loadb     = 1'b0;
        shift_in  = 2'b00;
        out_ready = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst_n     = v.rst_n;
        write     = v.wr;
        writenum  = v.wn;
        data_in   = v.din;
        readnum   = v.rn;
        loada     = v.la;
        loadb     = v.lb;
        shift_in  = v.sh;
        out_ready = v.ordy;
        @(posedge clk);
        #1;
        check($sformatf("v%0d_aout", idx),    aout,                 v.e_aout);
        check($sformatf("v%0d_bout", idx),    bout,                 v.e_bout);
        check($sformatf("v%0d_shift", idx),   {14'd0, shift_q},     {14'd0, v.e_sh});
        check($sformatf("v%0d_valid", idx),   {15'd0, out_valid},   {15'd0, v.e_valid});
        check($sformatf("v%0d_overrun", idx), {15'd0, overrun_err}, {15'd0, v.e_ovr});
    endtask

    initial begin
        int waited;
        drive_idle();
        rst_n = 1'b0;

        //                 rst  wr  wn    din       rn    la    lb    sh     ordy   aout      bout      sh     v     ovr
        vecs.push_back('{1'b0,1'b0,3'd0,16'h0000,3'd0,1'b0,1'b0,2'b00,1'b0, 16'h0000,16'h0000,2'b00,1'b0,1'b0}); // reset
        vecs.push_back('{1'b1,1'b1,3'd3,16'hBEEF,3'd0,1'b0,1'b0,2'b00,1'b0, 16'h0000,16'h0000,2'b00,1'b0,1'b0}); // R3=BEEF
        vecs.push_back('{1'b0,1'b0,3'd0,16'h0000,3'd0,1'b0,1'b0,2'b00,1'b0, 16'h0000,16'h0000,2'b00,1'b0,1'b0}); // reset
        vecs.push_back('{1'b1,1'b0,3'd0,16'h0000,3'd3,1'b1,1'b0,2'b00,1'b0, 16'h0000,16'h0000,2'b00,1'b0,1'b0}); // R3 cleared
        vecs.push_back('{1'b0,1'b0,3'd0,16'h0000,3'd0,1'b0,1'b0,2'b00,1'b0, 16'h0000,16'h0000,2'b00,1'b0,1'b0}); // reset
        vecs.push_back('{1'b1,1'b1,3'd2,16'h1234,3'd0,1'b0,1'b0,2'b00,1'b0, 16'h0000,16'h0000,2'b00,1'b0,1'b0}); // R2
        vecs.push_back('{1'b1,1'b1,3'd5,16'h8001,3'd0,1'b0,1'b0,2'b00,1'b0, 16'h0000,16'h0000,2'b00,1'b0,1'b0}); // R5
        vecs.push_back('{1'b1,1'b0,3'd0,16'h0000,3'd2,1'b1,1'b0,2'b00,1'b0, 16'h1234,16'h0000,2'b00,1'b0,1'b0}); // load A
        vecs.push_back('{1'b1,1'b0,3'd0,16'h0000,3'd5,1'b0,1'b1,2'b11,1'b0, 16'h1234,16'h8001,2'b11,1'b1,1'b0}); // load B
        vecs.push_back('{1'b1,1'b0,3'd0,16'h0000,3'd5,1'b1,1'b0,2'b00,1'b0, 16'h1234,16'h8001,2'b11,1'b1,1'b1}); // overrun
        vecs.push_back('{1'b1,1'b0,3'd0,16'h0000,3'd0,1'b0,1'b0,2'b00,1'b1, 16'h1234,16'h8001,2'b11,1'b0,1'b1}); // consume
        vecs.push_back('{1'b1,1'b0,3'd0,16'h0000,3'd2,1'b1,1'b1,2'b01,1'b0, 16'h1234,16'h1234,2'b01,1'b1,1'b1}); // A+B same cycle
        vecs.push_back('{1'b1,1'b0,3'd0,16'h0000,3'd5,1'b1,1'b1,2'b10,1'b1, 16'h8001,16'h8001,2'b10,1'b1,1'b1}); // back-to-back
        vecs.push_back('{1'b1,1'b1,3'd1,16'h0001,3'd0,1'b0,1'b0,2'b00,1'b1, 16'h8001,16'h8001,2'b10,1'b0,1'b1}); // R1=1, consume
        vecs.push_back('{1'b1,1'b1,3'd1,16'h00FF,3'd1,1'b0,1'b1,2'b00,1'b0, 16'h8001,COLL_EXP,2'b00,1'b0,1'b1}); // collision
        vecs.push_back('{1'b1,1'b0,3'd0,16'h0000,3'd1,1'b1,1'b0,2'b00,1'b0, 16'h00FF,COLL_EXP,2'b00,1'b1,1'b1}); // write landed
        vecs.push_back('{1'b0,1'b0,3'd0,16'h0000,3'd0,1'b0,1'b0,2'b00,1'b0, 16'h0000,16'h0000,2'b00,1'b0,1'b0}); // reset
        vecs.push_back('{1'b1,1'b1,3'd6,16'hA5A5,3'd0,1'b0,1'b0,2'b00,1'b0, 16'h0000,16'h0000,2'b00,1'b0,1'b0}); // R6
        vecs.push_back('{1'b1,1'b0,3'd0,16'h0000,3'd6,1'b1,1'b0,2'b00,1'b0, 16'hA5A5,16'h0000,2'b00,1'b0,1'b0}); // load A
        vecs.push_back('{1'b0,1'b0,3'd0,16'h0000,3'd6,1'b0,1'b1,2'b11,1'b0, 16'h0000,16'h0000,2'b00,1'b0,1'b0}); // reset mid-pair
        vecs.push_back('{1'b1,1'b0,3'd0,16'h0000,3'd6,1'b0,1'b1,2'b10,1'b0, 16'h0000,16'h0000,2'b10,1'b0,1'b0}); // A was dropped
        vecs.push_back('{1'b1,1'b0,3'd0,16'h0000,3'd6,1'b0,1'b1,2'b01,1'b0, 16'h0000,16'h0000,2'b10,1'b0,1'b1}); // B overrun

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // B is held (zero, code 10); write R4 then load A from it.
        @(negedge clk);
        drive_idle();
        write    = 1'b1;
        writenum = 3'd4;
        data_in  = 16'h0F0F;
        @(negedge clk);
        drive_idle();
        readnum = 3'd4;
        loada   = 1'b1;
        @(negedge clk);
        drive_idle();
        waited = 0;
        while (out_valid !== 1'b1 && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        check("pair_valid_timeout", {15'd0, out_valid}, 16'h0001);
        check("seq_aout", aout, 16'h0F0F);

        // Readiness follows out_ready combinationally while a pair is held.
        out_ready = 1'b0;
        #1;
        check("a_ready_blocked", {15'd0, a_ready}, 16'h0000);
        check("b_ready_blocked", {15'd0, b_ready}, 16'h0000);
        out_ready = 1'b1;
        #1;
        check("a_ready_consume", {15'd0, a_ready}, 16'h0001);
        check("b_ready_consume", {15'd0, b_ready}, 16'h0001);
        @(posedge clk);
        #1;
        check("drain_valid", {15'd0, out_valid}, 16'h0000);
        check("drain_a_ready", {15'd0, a_ready}, 16'h0001);
        check("drain_aout_hold", aout, 16'h0F0F);

        @(negedge clk);
        drive_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_operand_regfile_stage

// File: doc/operand_regfile_stage.md
Name: operand_regfile_stage

Overview:
- Datapath stage directly upstream of the 16-bit shifter: 8 x 16-bit register file plus operand latches A and B.
- B is latched together with a 2-bit shift code and drives the shifter's `in` and `shift` inputs; A bypasses the shifter to the ALU.
- A valid/ready handshake tells the downstream shifter/ALU stage when a complete operand pair is present. Pairs are consumed once.

Parameters:
- DW, 16, datapath word width. Shifter contract fixes it at 16.
- NREG, 8, number of architectural registers.
- RW, 3, register index width, $clog2(NREG).

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- write  in  1  register-file write enable.
- writenum  in  RW  write register index.
- data_in  in  DW  write data.
- readnum  in  RW  read register index, shared by loada and loadb.
- loada  in  1  latch R[readnum] into operand A.
- loadb  in  1  latch R[readnum] into operand B, and shift_in into shift_q.
- shift_in  in  2  shift code: 00 pass, 01 <<1, 10 >>1 logical, 11 >>1 arithmetic.
- a_ready  out  1  operand A latch can accept a load this cycle.
- b_ready  out  1  operand B latch can accept a load this cycle.
- aout  out  DW  latched operand A, to ALU.
- bout  out  DW  latched operand B, to shifter `in`.
- shift_q  out  2  latched shift code, to shifter `shift`.
- out_valid  out  1  A and B both hold unconsumed data.
- out_ready  in  1  downstream consumes the pair.
- overrun_err  out  1  sticky: a load was attempted while not ready.

Behaviour:
- Reset (rst_n=0 at posedge):
  - R0..R7 = 0; aout = 0, bout = 0, shift_q = 00.
  - a_full = 0, b_full = 0, out_valid = 0, overrun_err = 0.
  - Every pending operand is discarded, including during a handshake.
- Register file:
  - Combinational read R[readnum].
  - Write at posedge when write=1: R[writenum] <= data_in.
  - Write takes effect the cycle after.
- Occupancy:
  - a_full and b_full are internal flags.
  - out_valid = a_full & b_full, registered-flag derived with no combinational path from inputs.
  - consume = out_valid & out_ready.
- Ready rules:
  - a_ready = ~a_full | consume.
  - b_ready = ~b_full | consume.
  - Combinational from out_ready, which permits back-to-back pairs.
- Load A (loada & a_ready): aout <= R[readnum], a_full <= 1.
- Load B (loadb & b_ready):
  - bout <= R[readnum], shift_q <= shift_in, b_full <= 1.
  - shift_q never changes without a bout load.
- Consume without a reload: the corresponding flag clears. aout, bout and shift_q hold their values, because data is not zeroed.
- Simultaneous events:
  - Consume and load in the same cycle leaves the flag set with the new data.
  - loada and loadb in the same cycle both latch R[readnum].
- Overrun:
  - loada & ~a_ready, or loadb & ~b_ready, is ignored.
  - overrun_err <= 1 and stays set until reset.
- Read/write collision: write and load in the same cycle with writenum == readnum latch the OLD register value (read-before-write), unless the bypass feature is enabled.
- Latency:
  - Register write to latchable: 1 cycle.
  - Load to out_valid: 1 cycle after the second operand's load edge.
- Index range: indices ≥ NREG cannot occur when NREG = 2^RW. For other NREG, writes to such indices are dropped and reads return 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a load on the same cycle as a write with writenum == readnum latches data_in (write-through forwarding).
- Undefined: read-before-write as above.
- Bypass has no effect on the register-file contents.

Decomposition:
- Package datapath_pkg holds:
  - DW and shift-code constants: SH_PASS = 2'b00, SH_LSL = 2'b01, SH_LSR = 2'b10, SH_ASR = 2'b11.
  - typedef word_t (logic [15:0]).
  - typedef regidx_t (logic [2:0]).
- Sub-module regfile8x16: storage array, one write port, one combinational read port.
- Handshake flags, latches, bypass mux and overrun logic stay in the top.

Test Plan:
- Reset: write R3 = 16'hBEEF, then pulse rst_n=0 for 1 cycle -> R3 reads 0; aout, bout, out_valid and overrun_err all 0.
- Write R2 = 16'h1234 and R5 = 16'h8001; loada readnum=2, next cycle loadb readnum=5 shift_in=11 -> out_valid=1, aout=16'h1234, bout=16'h8001, shift_q=11.
- Backpressure:
  - With a pair held and out_ready=0, loada readnum=5 -> ignored, aout still 16'h1234, overrun_err=1.
  - Then out_ready=1 -> out_valid=0 next cycle.
- Back-to-back: out_valid=1, out_ready=1, with loada and loadb same cycle, readnum=5 -> out_valid remains 1, aout = bout = 16'h8001.
- Collision: R1 = 16'h0001; write R1 = 16'h00FF with loadb readnum=1 same cycle -> bout = 16'h0001 (macro undefined) or 16'h00FF (REGFILE_BYPASS_EN).
- Reset mid-pair: loada done, rst_n=0 on the same cycle as loadb -> a_full = b_full = 0 and bout = 0 after the edge.
